// File: rtl/mram_serial_host.sv
// Host-side serial initiator for the MRAM bridge: shifts one command's address/data out
// MSB first, waits for the memory, and for reads deserialises the returned word.
module mram_serial_host #(
  parameter int         ADDR_WIDTH = 20,
  parameter int         DATA_WIDTH = 16,
  parameter int         MEM_WAIT   = 4,
  parameter logic [2:0] SEL_IDLE   = 3'b000,
  parameter logic [2:0] SEL_READ   = 3'b001,
  parameter logic [2:0] SEL_WRITE  = 3'b010
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [2:0]            read_write_sel,
  output logic                  ser_addr_out,
  output logic                  ser_wdata_out,
  input  logic                  ser_rdata_in
);

  localparam int CNT_MAX = (ADDR_WIDTH > MEM_WAIT) ? ADDR_WIDTH : MEM_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic [ADDR_WIDTH-1:0] wdata_sh_q, wdata_sh_d;
  logic [DATA_WIDTH-1:0] rdata_sh_q, rdata_sh_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic [2:0]            sel_q, sel_d;
  logic                  ser_addr_q, ser_addr_d;
  logic                  ser_wdata_q, ser_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] wdata_ext;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_sh_d   = addr_sh_q;
    wdata_sh_d  = wdata_sh_q;
    rdata_sh_d  = rdata_sh_q;
    rsp_rdata_d = rsp_rdata_q;
    ser_addr_d  = 1'b0;
    ser_wdata_d = 1'b0;
    rsp_valid_d = 1'b0;
    // Data is right-aligned in the address-wide frame so its LSB lands with the address LSB.
    wdata_ext   = cmd_write ? ADDR_WIDTH'(cmd_wdata) : '0;

    // Outputs are registered, so each branch prepares the serial bits for the next cycle.
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = S_SHIFT;
          cnt_d       = '0;
          write_d     = cmd_write;
          ser_addr_d  = cmd_addr[ADDR_WIDTH-1];
          addr_sh_d   = cmd_addr << 1;
          ser_wdata_d = wdata_ext[ADDR_WIDTH-1];
          wdata_sh_d  = wdata_ext << 1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (MEM_WAIT > 0) begin
            state_d = S_WAIT;
          end else if (!write_q) begin
            state_d = S_CAPTURE;
          end else begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
          end
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          ser_addr_d  = addr_sh_q[ADDR_WIDTH-1];
          addr_sh_d   = addr_sh_q << 1;
          ser_wdata_d = wdata_sh_q[ADDR_WIDTH-1];
          wdata_sh_d  = wdata_sh_q << 1;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d = '0;
          if (write_q) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = S_CAPTURE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        rdata_sh_d = (rdata_sh_q << 1) | DATA_WIDTH'(ser_rdata_in);
        if (cnt_q == CAP_LAST) begin
          cnt_d       = '0;
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata_sh_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_SHIFT || state_d == S_WAIT || state_d == S_CAPTURE) begin
      sel_d = write_d ? SEL_WRITE : SEL_READ;
    end else begin
      sel_d = SEL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_sh_q   <= '0;
      wdata_sh_q  <= '0;
      rdata_sh_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      sel_q       <= SEL_IDLE;
      ser_addr_q  <= 1'b0;
      ser_wdata_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_sh_q   <= addr_sh_d;
      wdata_sh_q  <= wdata_sh_d;
      rdata_sh_q  <= rdata_sh_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
      ser_addr_q  <= ser_addr_d;
      ser_wdata_q <= ser_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign read_write_sel = sel_q;
  assign ser_addr_out   = ser_addr_q;
  assign ser_wdata_out  = ser_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;

endmodule

// File: tb/tb_mram_serial_host.sv
// Directed bench for mram_serial_host: default instance plus a MEM_WAIT=0 instance.
module tb_mram_serial_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        ser_rdata_in = 1'b0;
  logic        cmd_ready, rsp_valid, busy, ser_addr_out, ser_wdata_out;
  logic [15:0] rsp_rdata;
  logic [2:0]  read_write_sel;

  logic        z_cmd_valid = 1'b0, z_cmd_write = 1'b0;
  logic [19:0] z_cmd_addr = '0;
  logic [15:0] z_cmd_wdata = '0;
  logic        z_ser_rdata_in = 1'b0;
  logic        z_cmd_ready, z_rsp_valid, z_busy, z_ser_addr_out, z_ser_wdata_out;
  logic [15:0] z_rsp_rdata;
  logic [2:0]  z_read_write_sel;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_rdata = 16'h0;

  always #5 clk = ~clk;

  mram_serial_host dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .read_write_sel(read_write_sel), .ser_addr_out(ser_addr_out),
    .ser_wdata_out(ser_wdata_out), .ser_rdata_in(ser_rdata_in)
  );

  mram_serial_host #(.MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready),
    .cmd_write(z_cmd_write), .cmd_addr(z_cmd_addr), .cmd_wdata(z_cmd_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .busy(z_busy),
    .read_write_sel(z_read_write_sel), .ser_addr_out(z_ser_addr_out),
    .ser_wdata_out(z_ser_wdata_out), .ser_rdata_in(z_ser_rdata_in)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs, exp;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready_low: got %b expected 0", cmd_ready);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      obs = {read_write_sel, ser_addr_out, ser_wdata_out, rsp_valid, busy, cmd_ready};
      exp = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs, exp);
      end
      step();
    end
    checks++;
    if (rsp_rdata !== 16'h0 || z_cmd_ready !== 1'b1 || z_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdata_dut0: rdata %h z_ready %b z_busy %b expected 0000 1 0",
               rsp_rdata, z_cmd_ready, z_busy);
    end
  endtask

  task automatic test_write();
    logic [19:0] a  = 20'hA5F3C;
    logic [15:0] w  = 16'hBEEF;
    logic [19:0] wz = {4'h0, 16'hBEEF};
    logic [7:0]  obs, exp;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_before: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = w;
    for (int i = 1; i <= 26; i++) begin
      step();
      if (i == 1) begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 20'hFFFFF; cmd_wdata = 16'h0000;
      end
      if (i <= 20)      exp = {3'b010, a[20-i], wz[20-i], 1'b0, 1'b1, 1'b0};
      else if (i <= 24) exp = {3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      else if (i == 25) exp = {3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      else              exp = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      obs = {read_write_sel, ser_addr_out, ser_wdata_out, rsp_valid, busy, cmd_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wr_cycle T+%0d: got %b expected %b", i, obs, exp);
      end
      if (i >= 25) begin
        checks++;
        if (rsp_rdata !== last_rdata) begin
          errors++;
          $display("FAIL wr_rdata_hold T+%0d: got %h expected %h", i, rsp_rdata, last_rdata);
        end
      end
    end
  endtask

  task automatic test_read();
    logic [19:0] a = 20'h00001;
    logic [15:0] d = 16'h1234;
    logic [7:0]  obs, exp;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_wdata = 16'hAAAA;
    for (int i = 1; i <= 42; i++) begin
      step();
      if (i == 1) cmd_valid = 1'b0;
      ser_rdata_in = (i >= 25 && i <= 40) ? d[15-(i-25)] : 1'b0;
      if (i <= 20)      exp = {3'b001, a[20-i], 1'b0, 1'b0, 1'b1, 1'b0};
      else if (i <= 40) exp = {3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      else if (i == 41) exp = {3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      else              exp = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      obs = {read_write_sel, ser_addr_out, ser_wdata_out, rsp_valid, busy, cmd_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rd_cycle T+%0d: got %b expected %b", i, obs, exp);
      end
      if (i >= 41) begin
        checks++;
        if (rsp_rdata !== d) begin
          errors++;
          $display("FAIL rd_rdata T+%0d: got %h expected %h", i, rsp_rdata, d);
        end
      end
    end
    last_rdata = d;
  endtask

  task automatic test_wait0();
    logic [19:0] a = 20'h12345;
    logic [15:0] d = 16'hFFFF;
    logic [7:0]  obs, exp;
    z_cmd_valid = 1'b1; z_cmd_write = 1'b0; z_cmd_addr = a;
    for (int i = 1; i <= 38; i++) begin
      step();
      if (i == 1) z_cmd_valid = 1'b0;
      z_ser_rdata_in = (i >= 21 && i <= 36) ? d[15-(i-21)] : 1'b0;
      if (i <= 20)      exp = {3'b001, a[20-i], 1'b0, 1'b0, 1'b1, 1'b0};
      else if (i <= 36) exp = {3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      else if (i == 37) exp = {3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      else              exp = {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      obs = {z_read_write_sel, z_ser_addr_out, z_ser_wdata_out, z_rsp_valid, z_busy, z_cmd_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL w0_cycle T+%0d: got %b expected %b", i, obs, exp);
      end
    end
    checks++;
    if (z_rsp_rdata !== d) begin
      errors++;
      $display("FAIL w0_rdata: got %h expected %h", z_rsp_rdata, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] wa  = 20'h3C0F1;
    logic [19:0] wwz = {4'h0, 16'h5A5A};
    logic [19:0] ra  = 20'hF0001;
    logic [15:0] rd  = 16'hC3A5;
    logic [19:0] w2z = {4'h0, 16'h1111};
    logic [2:0]  obs, exp;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = wa; cmd_wdata = 16'h5A5A;
    for (int c = 1; c <= 94; c++) begin
      step();
      if (c == 1) begin
        cmd_write = 1'b0; cmd_addr = ra; cmd_wdata = 16'hFFFF;
      end
      if (c == 27) begin
        cmd_write = 1'b1; cmd_addr = 20'h00ABC; cmd_wdata = 16'h1111;
      end
      if (c == 69) cmd_valid = 1'b0;
      ser_rdata_in = (c >= 51 && c <= 66) ? rd[15-(c-51)] : 1'b0;
      obs = {cmd_ready, rsp_valid, busy};
      exp = {(c == 26 || c == 68 || c == 94), (c == 25 || c == 67 || c == 93),
             !(c == 26 || c == 68 || c == 94)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_handshake T0+%0d: got %b expected %b", c, obs, exp);
      end
      if (c <= 20) begin
        checks++;
        if ({read_write_sel, ser_addr_out, ser_wdata_out} !== {3'b010, wa[20-c], wwz[20-c]}) begin
          errors++;
          $display("FAIL b2b_wr1_shift T0+%0d: got %b expected %b", c,
                   {read_write_sel, ser_addr_out, ser_wdata_out}, {3'b010, wa[20-c], wwz[20-c]});
        end
      end
      if (c >= 27 && c <= 46) begin
        checks++;
        if ({read_write_sel, ser_addr_out, ser_wdata_out} !== {3'b001, ra[46-c], 1'b0}) begin
          errors++;
          $display("FAIL b2b_rd_shift T0+%0d: got %b expected %b", c,
                   {read_write_sel, ser_addr_out, ser_wdata_out}, {3'b001, ra[46-c], 1'b0});
        end
      end
      if (c >= 69 && c <= 88) begin
        checks++;
        if ({read_write_sel, ser_wdata_out} !== {3'b010, w2z[88-c]}) begin
          errors++;
          $display("FAIL b2b_wr2_shift T0+%0d: got %b expected %b", c,
                   {read_write_sel, ser_wdata_out}, {3'b010, w2z[88-c]});
        end
      end
      if (c == 25 || c == 67 || c == 93) begin
        checks++;
        if (rsp_rdata !== ((c == 25) ? last_rdata : rd)) begin
          errors++;
          $display("FAIL b2b_rdata T0+%0d: got %h expected %h", c, rsp_rdata,
                   (c == 25) ? last_rdata : rd);
        end
      end
    end
    last_rdata = rd;
  endtask

  task automatic test_reset_mid();
    logic [19:0] a = 20'h0000F;
    logic [15:0] d = 16'h0F0F;
    logic [7:0]  obs;
    int          rv_seen = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h55555;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) cmd_valid = 1'b0;
    end
    rst = 1'b1;
    step();
    obs = {read_write_sel, ser_addr_out, ser_wdata_out, rsp_valid, busy, cmd_ready};
    checks++;
    if (obs !== 8'h00 || rsp_rdata !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b rdata %h expected 00000000 rdata 0000", obs, rsp_rdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (rsp_valid === 1'b1 || rsp_valid === 1'bx) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_aftermath: rsp_valid seen %0d ready %b busy %b expected 0 1 0",
               rv_seen, cmd_ready, busy);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
    for (int i = 1; i <= 41; i++) begin
      step();
      if (i == 1) cmd_valid = 1'b0;
      ser_rdata_in = (i >= 25 && i <= 40) ? d[15-(i-25)] : 1'b0;
      checks++;
      if (rsp_valid !== (i == 41)) begin
        errors++;
        $display("FAIL mid_next_valid T+%0d: got %b expected %b", i, rsp_valid, (i == 41));
      end
      if (i <= 20) begin
        checks++;
        if (ser_addr_out !== a[20-i]) begin
          errors++;
          $display("FAIL mid_next_addr T+%0d: got %b expected %b", i, ser_addr_out, a[20-i]);
        end
      end
    end
    checks++;
    if (rsp_rdata !== d) begin
      errors++;
      $display("FAIL mid_next_rdata: got %h expected %h", rsp_rdata, d);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait0();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
